// File: rtl/sm_accum_ctrl_pkg.sv
// rtl/sm_accum_ctrl_pkg.sv - shared types and helpers for the sign-magnitude accumulator
package sm_accum_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A zero magnitude always carries a positive sign so -0 never escapes.
    function automatic logic norm_sign(input logic sign, input logic mag_zero);
        return sign & ~mag_zero;
    endfunction

endpackage

// File: rtl/sm_accum_ctrl_if.sv
// rtl/sm_accum_ctrl_if.sv - term stream, result handshake and status bundle
interface sm_accum_ctrl_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int TERMS     = 8
);
    localparam int CNT_W = $clog2(TERMS + 1);

    logic                 start;
    logic [WIDTH-1:0]     data;
    logic                 valid;
    logic                 ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 res_valid;
    logic                 ack;
    logic                 ovf;
    logic                 busy;
    logic [CNT_W-1:0]     count;

    modport master (
        output start, data, valid, ack,
        input  ready, result, res_valid, ovf, busy, count
    );

    modport slave (
        input  start, data, valid, ack,
        output ready, result, res_valid, ovf, busy, count
    );

endinterface

// File: rtl/sm_accum_ctrl_add_sat.sv
// rtl/sm_accum_ctrl_add_sat.sv - combinational saturating sign-magnitude adder
module sm_accum_ctrl_add_sat
    import sm_accum_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH = 24
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);
    localparam int MW = ACC_WIDTH - 1;

    logic          sign_a;
    logic          sign_b;
    logic [MW-1:0] mag_a;
    logic [MW-1:0] mag_b;
    logic [MW:0]   mag_sum;
    logic [MW-1:0] mag_r;
    logic          sign_r;

    assign sign_a  = a[MW];
    assign sign_b  = b[MW];
    assign mag_a   = a[MW-1:0];
    assign mag_b   = b[MW-1:0];
    // One extra bit catches magnitude overflow on like-signed adds.
    assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

    // Like signs add magnitudes with clamping; unlike signs subtract the smaller from the larger.
    always_comb begin
        mag_r  = '0;
        sign_r = 1'b0;
        ovf    = 1'b0;
        if (sign_a == sign_b) begin
            sign_r = sign_a;
            if (mag_sum[MW]) begin
                mag_r = '1;
                ovf   = 1'b1;
            end else begin
                mag_r = mag_sum[MW-1:0];
            end
        end else if (mag_a >= mag_b) begin
            mag_r  = mag_a - mag_b;
            sign_r = sign_a;
        end else begin
            mag_r  = mag_b - mag_a;
            sign_r = sign_b;
        end
        sum = {norm_sign(sign_r, mag_r == '0), mag_r};
    end

endmodule

// File: rtl/sm_accum_ctrl.sv
// rtl/sm_accum_ctrl.sv - sequencer folding TERMS sign-magnitude terms into one saturating sum
module sm_accum_ctrl
    import sm_accum_ctrl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 24,
    parameter int TERMS     = 8
) (
    input logic           clk,
    input logic           rst,
    sm_accum_ctrl_if.slave bus
);
    localparam int               CNT_W = $clog2(TERMS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TERMS - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] term_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 add_ovf;
    logic [CNT_W-1:0]     count;
    logic                 ready;
    logic                 res_valid;
    logic                 busy;
    logic                 ovf;

    // Sign moves to the accumulator MSB; the magnitude is zero-extended.
    assign term_ext = {bus.data[WIDTH-1], {(ACC_WIDTH-WIDTH){1'b0}}, bus.data[WIDTH-2:0]};

    sm_accum_ctrl_add_sat #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_add_sat (
        .a  (acc),
        .b  (term_ext),
        .sum(sum),
        .ovf(add_ovf)
    );

    // Control FSM with registered handshake/status outputs, counter and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            ready     <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_ACC;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        ready <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (bus.valid) begin
                        acc   <= sum;
                        ovf   <= ovf | add_ovf;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state     <= ST_DONE;
                            ready     <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.ack) begin
                        res_valid <= 1'b0;
                        if (bus.start) begin
                            state <= ST_ACC;
                            acc   <= '0;
                            count <= '0;
                            ovf   <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ready     <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready;
    assign bus.res_valid = res_valid;
    assign bus.result    = acc;
    assign bus.ovf       = ovf;
    assign bus.busy      = busy;
    assign bus.count     = count;

endmodule
